mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single port of one `generic_memory` instance among `NUM_REQ` requesters. It grants at most one request per cycle, drives the memory's address, write-data and write-enable inputs, and routes the registered read data back to the requester that issued the read. It sits directly in front of the memory, and its payload type `T` matches the memory's `T`.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of requester handshake, response and memory-port
//               signals shared between mem_port_arbiter and its neighbours.
//   slave  modport : arbiter side (takes requests and read data, drives
//                    grants, responses and the memory address/data/enable)
//   master modport : requester/memory side (the mirror image)
//   req_valid/req_ready/req_addr/req_we/req_wdata : per-requester request
//   rsp_valid/rsp_data                            : read response
//   mem_addr/mem_write_data/mem_write_en/mem_read_data : memory port
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter type T       = logic [31:0],
  parameter int  NUM_REQ = 2,
  parameter int  ADDR_W  = 8
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_we;
  T     [NUM_REQ-1:0]             req_wdata;
  logic [NUM_REQ-1:0]             rsp_valid;
  T                               rsp_data;
  logic [ADDR_W-1:0]              mem_addr;
  T                               mem_write_data;
  logic                           mem_write_en;
  T                               mem_read_data;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_write_data, mem_write_en
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_write_data, mem_write_en
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing the single port of one memory
//               with a registered (1-cycle) read among NUM_REQ requesters.
//               At most one request is granted per cycle; the winner drives
//               the memory port combinationally and read data is routed back
//               to the requester that issued the read one cycle later.
// Ports       : clk   - clock, all state on the rising edge
//               rst_n - asynchronous active-low reset
//               bus   - mem_port_arbiter_if.slave (requests, grants,
//                       responses and memory port)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter type T       = logic [31:0],
  parameter int  NUM_REQ = 2,
  parameter int  ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int               PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   c_num_req = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] c_last    = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] r_ptr;      // highest-priority requester this cycle
  logic             r_rd_pend;  // read granted last cycle, data arrives now
  logic [PTR_W-1:0] r_rd_id;    // requester owning the pending read

  logic             w_grant;
  logic [PTR_W-1:0] w_gidx;
  logic             w_grant_rd;
  logic [ADDR_W-1:0] w_mem_addr;
  T                 w_mem_wdata;
  logic             w_mem_we;

  // Rotating priority search starting at r_ptr. The sum is one bit wider
  // than the pointer so ptr+k can exceed NUM_REQ-1 before being folded back.
  always_comb begin
    logic [PTR_W:0] v_sum;
    v_sum   = '0;
    w_grant = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (v_sum >= c_num_req) begin
        v_sum = v_sum - c_num_req;
      end
      if (!w_grant && bus.req_valid[v_sum[PTR_W-1:0]]) begin
        w_grant = 1'b1;
        w_gidx  = v_sum[PTR_W-1:0];
      end
    end
  end

  assign w_grant_rd = w_grant && !bus.req_we[w_gidx];

  // Memory port: winner's request, or all-zero when nobody is granted.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    if (w_grant) begin
      w_mem_addr  = bus.req_addr[w_gidx];
      w_mem_wdata = bus.req_wdata[w_gidx];
      w_mem_we    = bus.req_we[w_gidx];
    end
  end

  assign bus.mem_addr       = w_mem_addr;
  assign bus.mem_write_data = w_mem_wdata;
  assign bus.mem_write_en   = w_mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_id   <= '0;
    end else begin
      // The winner drops to lowest priority; the pointer holds when idle.
      if (w_grant) begin
        r_ptr <= (w_gidx == c_last) ? '0 : w_gidx + PTR_W'(1);
      end
      r_rd_pend <= w_grant_rd;
      if (w_grant_rd) begin
        r_rd_id <= w_gidx;
      end
    end
  end

  // Read data from the memory is already registered, so it lines up with
  // r_rd_pend; it is gated to zero outside a response cycle.
  assign bus.rsp_data = r_rd_pend ? bus.mem_read_data : '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    assign bus.req_ready[i] = w_grant && (w_gidx == PTR_W'(i));
    assign bus.rsp_valid[i] = r_rd_pend && (r_rd_id == PTR_W'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with four
//               requesters and a 64-bit payload, driving a small registered-
//               read memory model behind the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  typedef logic [63:0] data_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.T(data_t), .NUM_REQ(4), .ADDR_W(8)) bus ();

  mem_port_arbiter #(.T(data_t), .NUM_REQ(4), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Memory behind the arbiter: synchronous write, registered read.
  // While preload is set every word is filled with address + 0x100.
  data_t mem [256];
  bit    preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) mem[a] <= data_t'(a) + 64'h100;
    end else if (bus.mem_write_en) begin
      mem[bus.mem_addr] <= bus.mem_write_data;
    end
    bus.mem_read_data <= mem[bus.mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input data_t got, input data_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input logic [1:0] i, input bit we, input logic [7:0] a, input data_t d);
    bus.req_valid[i] = 1'b1;
    bus.req_we[i]    = we;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = d;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] prev;

    // ---------------- reset state ----------------
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    settle();
    check("reset_ready",     data_t'(bus.req_ready),      64'd0);
    check("reset_rsp_valid", data_t'(bus.rsp_valid),      64'd0);
    check("reset_rsp_data",  bus.rsp_data,                64'd0);
    check("reset_mem_addr",  data_t'(bus.mem_addr),       64'd0);
    check("reset_mem_we",    data_t'(bus.mem_write_en),   64'd0);
    check("reset_mem_wdata", bus.mem_write_data,          64'd0);
    preload = 1'b0;
    rst_n   = 1'b1;

    // ---------------- write then read, requester 0 ----------------
    step(); idle(); set_req(2'd0, 1'b1, 8'h10, 64'hDEADBEEF); settle();
    check("wr_ready",     data_t'(bus.req_ready),    64'b0001);
    check("wr_mem_addr",  data_t'(bus.mem_addr),     64'h10);
    check("wr_mem_we",    data_t'(bus.mem_write_en), 64'd1);
    check("wr_mem_wdata", bus.mem_write_data,        64'hDEADBEEF);
    step(); idle(); set_req(2'd0, 1'b0, 8'h10, 64'd0); settle();
    check("rd_ready",     data_t'(bus.req_ready),    64'b0001);
    check("rd_mem_we",    data_t'(bus.mem_write_en), 64'd0);
    check("wr_no_rsp",    data_t'(bus.rsp_valid),    64'd0);
    step(); idle(); settle();
    check("rd_rsp_valid", data_t'(bus.rsp_valid),    64'b0001);
    check("rd_rsp_data",  bus.rsp_data,              64'hDEADBEEF);
    check("idle_ready",   data_t'(bus.req_ready),    64'd0);
    check("idle_addr",    data_t'(bus.mem_addr),     64'd0);

    // ---------------- reset during an in-flight read ----------------
    step(); idle(); set_req(2'd0, 1'b0, 8'h10, 64'd0); settle();
    check("rst_rd_grant", data_t'(bus.req_ready), 64'b0001);
    step(); idle(); settle();
    check("rst_inflight", data_t'(bus.rsp_valid), 64'b0001);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", data_t'(bus.rsp_valid), 64'd0);
    check("rst_async_data",  bus.rsp_data,           64'd0);
    step(); step();
    rst_n = 1'b1;
    settle();
    check("rst_release_valid", data_t'(bus.rsp_valid), 64'd0);
    step(); idle();
    set_req(2'd0, 1'b0, 8'h10, 64'd0);
    set_req(2'd1, 1'b0, 8'h11, 64'd0);
    settle();
    check("rst_ptr0_grant", data_t'(bus.req_ready), 64'b0001);
    check("rst_no_late_rsp", data_t'(bus.rsp_valid), 64'd0);
    step(); idle(); set_req(2'd1, 1'b0, 8'h11, 64'd0); settle();
    check("two_req1_grant", data_t'(bus.req_ready), 64'b0010);
    check("two_rsp0_valid", data_t'(bus.rsp_valid), 64'b0001);
    check("two_rsp0_data",  bus.rsp_data,           64'hDEADBEEF);
    step(); idle(); settle();
    check("two_rsp1_valid", data_t'(bus.rsp_valid), 64'b0010);
    check("two_rsp1_data",  bus.rsp_data,           64'h111);

    // ---------------- round-robin fairness, all four reading ----------------
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); idle();
      for (int i = 0; i < 4; i++) set_req(2'(i), 1'b0, 8'(8'h30 + i), 64'd0);
      settle();
      g    = 2'(k);
      prev = g - 2'd1;
      check("rr_grant", data_t'(bus.req_ready), data_t'(4'b0001 << g));
      check("rr_addr",  data_t'(bus.mem_addr),  data_t'(8'h30) + data_t'(g));
      if (k == 0) begin
        check("rr_first_rsp", data_t'(bus.rsp_valid), 64'd0);
      end else begin
        check("rr_rsp_valid", data_t'(bus.rsp_valid), data_t'(4'b0001 << prev));
        check("rr_rsp_data",  bus.rsp_data,           64'h130 + data_t'(prev));
      end
    end
    step(); idle(); settle();
    check("rr_last_valid", data_t'(bus.rsp_valid), 64'b1000);
    check("rr_last_data",  bus.rsp_data,           64'h133);

    // ---------------- pointer hold across idle cycles ----------------
    step(); idle(); set_req(2'd2, 1'b0, 8'h02, 64'd0); settle();
    check("hold_req2_grant", data_t'(bus.req_ready), 64'b0100);
    step(); idle(); settle();
    check("hold_rsp2_valid", data_t'(bus.rsp_valid), 64'b0100);
    check("hold_rsp2_data",  bus.rsp_data,           64'h102);
    step(); step(); settle();
    check("hold_idle_ready", data_t'(bus.req_ready), 64'd0);
    step(); idle();
    set_req(2'd1, 1'b0, 8'h01, 64'd0);
    set_req(2'd3, 1'b0, 8'h03, 64'd0);
    settle();
    check("hold_req3_first", data_t'(bus.req_ready), 64'b1000);
    step(); settle();
    check("hold_req1_next",  data_t'(bus.req_ready), 64'b0010);
    check("hold_rsp3_valid", data_t'(bus.rsp_valid), 64'b1000);
    check("hold_rsp3_data",  bus.rsp_data,           64'h103);
    step(); idle(); settle();
    check("hold_rsp1_valid", data_t'(bus.rsp_valid), 64'b0010);
    check("hold_rsp1_data",  bus.rsp_data,           64'h101);

    // ---------------- interleaved write/read to the same address ----------------
    step(); idle(); set_req(2'd3, 1'b0, 8'h03, 64'd0); settle();
    check("il_align_grant", data_t'(bus.req_ready), 64'b1000);
    step(); idle();
    set_req(2'd0, 1'b1, 8'h20, 64'h55);
    set_req(2'd1, 1'b0, 8'h20, 64'd0);
    settle();
    check("il_wr_first",    data_t'(bus.req_ready),    64'b0001);
    check("il_wr_we",       data_t'(bus.mem_write_en), 64'd1);
    check("il_wr_addr",     data_t'(bus.mem_addr),     64'h20);
    check("il_prev_rsp",    data_t'(bus.rsp_valid),    64'b1000);
    step(); idle(); set_req(2'd1, 1'b0, 8'h20, 64'd0); settle();
    check("il_rd_grant",    data_t'(bus.req_ready),    64'b0010);
    check("il_rd_we",       data_t'(bus.mem_write_en), 64'd0);
    check("il_wr_no_rsp",   data_t'(bus.rsp_valid),    64'd0);
    step(); idle(); settle();
    check("il_rd_valid",    data_t'(bus.rsp_valid),    64'b0010);
    check("il_rd_data",     bus.rsp_data,              64'h55);

    // ---------------- wide payload and top address ----------------
    step(); idle(); set_req(2'd2, 1'b1, 8'hFF, 64'h0123456789ABCDEF); settle();
    check("wide_wr_grant", data_t'(bus.req_ready), 64'b0100);
    check("wide_wr_data",  bus.mem_write_data,     64'h0123456789ABCDEF);
    step(); idle(); set_req(2'd2, 1'b0, 8'hFF, 64'd0); settle();
    check("wide_rd_grant", data_t'(bus.req_ready), 64'b0100);
    check("wide_wr_norsp", data_t'(bus.rsp_valid), 64'd0);
    step(); idle(); set_req(2'd2, 1'b0, 8'h00, 64'd0); settle();
    check("wide_rd_valid", data_t'(bus.rsp_valid), 64'b0100);
    check("wide_rd_data",  bus.rsp_data,           64'h0123456789ABCDEF);
    step(); idle(); settle();
    check("wide_a0_valid", data_t'(bus.rsp_valid), 64'b0100);
    check("wide_a0_data",  bus.rsp_data,           64'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
